// File: rtl/dmem_responder.sv
// dmem_responder: M-stage data-memory responder.
// Captures one CPU load/store, issues a word request with byte mask to a
// variable-latency memory, stalls the pipeline until the access completes,
// and returns the sign/zero-extended load result.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for a CPU access; accepted access latched here
// S_REQ  | mem_req_valid high, fields frozen until mem_req_ready
// S_WAIT | waiting for mem_resp_valid, timeout counter running
// S_DONE | access finished, stall released, CPU ports ignored
module dmem_responder #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_we,
  input  logic        cpu_re,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [1:0]  st_size,
  input  logic [2:0]  ld_size,
  output logic        stall,
  output logic [31:0] cpu_rdata,
  output logic        err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_rw,
  output logic [29:0] mem_req_addr,
  output logic [31:0] mem_req_data,
  output logic [3:0]  mem_req_mask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic [1:0]  off_q;
  logic [2:0]  ld_size_q;

  logic        st_ok;
  logic        ld_ok;
  logic        accept;
  logic        bad;
  logic [3:0]  st_mask;
  logic [31:0] st_data;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] ld_result;

  // request qualification: a store wins over a simultaneous load
  always_comb begin
    st_ok  = (st_size != 2'b11);
    ld_ok  = (ld_size == 3'b000) || (ld_size == 3'b001) || (ld_size == 3'b010) ||
             (ld_size == 3'b100) || (ld_size == 3'b101);
    accept = cpu_we ? st_ok : (cpu_re & ld_ok);
    bad    = (cpu_we & cpu_re) | (cpu_we & ~st_ok) | (~cpu_we & cpu_re & ~ld_ok);
  end

  // store lane steering: replicate data, position the byte enables
  always_comb begin
    st_mask = 4'b1111;
    st_data = cpu_wdata;
    case (st_size)
      2'b00: begin
        st_mask = 4'b0001 << cpu_addr[1:0];
        st_data = {4{cpu_wdata[7:0]}};
      end
      2'b01: begin
        st_mask = 4'b0011 << {cpu_addr[1], 1'b0};
        st_data = {2{cpu_wdata[15:0]}};
      end
      default: begin
        st_mask = 4'b1111;
        st_data = cpu_wdata;
      end
    endcase
  end

  // load extraction from the returned word using the latched offset/size
  always_comb begin
    rd_half = off_q[1] ? mem_resp_data[31:16] : mem_resp_data[15:0];
    case (off_q)
      2'd0:    rd_byte = mem_resp_data[7:0];
      2'd1:    rd_byte = mem_resp_data[15:8];
      2'd2:    rd_byte = mem_resp_data[23:16];
      default: rd_byte = mem_resp_data[31:24];
    endcase
    case (ld_size_q)
      3'b000:  ld_result = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  ld_result = {{16{rd_half[15]}}, rd_half};
      3'b010:  ld_result = mem_resp_data;
      3'b100:  ld_result = {24'd0, rd_byte};
      3'b101:  ld_result = {16'd0, rd_half};
      default: ld_result = 32'd0;
    endcase
  end

  // pipeline freeze; forced low while reset is held so the pipe drops at once
  always_comb begin
    stall = 1'b0;
    if (reset) begin
      case (state)
        S_IDLE:  stall = accept;
        S_REQ:   stall = 1'b1;
        S_WAIT:  stall = 1'b1;
        default: stall = 1'b0;
      endcase
    end
  end

  // access sequencer with registered request, result and error outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      cnt           <= 8'd0;
      off_q         <= 2'd0;
      ld_size_q     <= 3'd0;
      cpu_rdata     <= 32'd0;
      err           <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_rw    <= 1'b0;
      mem_req_addr  <= 30'd0;
      mem_req_data  <= 32'd0;
      mem_req_mask  <= 4'd0;
    end else begin
      err <= 1'b0;
      case (state)
        S_IDLE: begin
          err <= bad;
          if (accept) begin
            mem_req_valid <= 1'b1;
            mem_req_rw    <= cpu_we;
            mem_req_addr  <= cpu_addr[31:2];
            mem_req_data  <= cpu_we ? st_data : 32'd0;
            mem_req_mask  <= cpu_we ? st_mask : 4'd0;
            off_q         <= cpu_addr[1:0];
            ld_size_q     <= ld_size;
            state         <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            cnt           <= 8'd0;
            state         <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_resp_valid) begin
            if (!mem_req_rw) cpu_rdata <= ld_result;
            state <= S_DONE;
          end else if (cnt == CNT_LAST) begin
            if (!mem_req_rw) cpu_rdata <= 32'd0;
            err   <= 1'b1;
            state <= S_DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder with a randomized
// backing-memory model and a behavioural load/store reference.
module tb_dmem_responder;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_we, cpu_re;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [1:0]  st_size;
  logic [2:0]  ld_size;
  logic        stall;
  logic [31:0] cpu_rdata;
  logic        err;
  logic        mem_req_valid, mem_req_ready, mem_req_rw;
  logic [29:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic [3:0]  mem_req_mask;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  dmem_responder #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .cpu_we(cpu_we), .cpu_re(cpu_re),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .st_size(st_size), .ld_size(ld_size),
    .stall(stall), .cpu_rdata(cpu_rdata), .err(err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_mask(mem_req_mask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } req_t;

  req_t        req_q[$];
  logic [31:0] comp_q[$];
  int          checks = 0;
  int          passes = 0;
  logic [31:0] last_rdata = 32'd0;

  // memory model knobs
  int          ready_lat = 0;
  int          resp_lat  = 0;
  bit          never_resp = 1'b0;
  logic [31:0] rd_word = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [3:0] model_mask(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd0) return 4'(1 << (a % 4));
    if (sz == 2'd1) return 4'(3 << (a & 2));
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] w);
    if (sz == 2'd0) return (w & 32'hFF) * 32'h01010101;
    if (sz == 2'd1) return (w & 32'hFFFF) * 32'h00010001;
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] lds, input logic [31:0] a,
                                             input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * (a % 4))) & 32'hFF;
    h = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    case (lds)
      3'd0:    return (b >= 128) ? b + 32'hFFFFFF00 : b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF0000 : h;
      3'd2:    return w;
      3'd4:    return b;
      3'd5:    return h;
      default: return 32'd0;
    endcase
  endfunction

  // backing memory: ready after ready_lat REQ cycles, response after resp_lat
  // WAIT cycles; random junk response on the accept cycle; late response
  // after a timeout
  initial begin
    int phase = 0;
    int cnt = 0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'd0;
    forever begin
      @(negedge clk);
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_data  = $urandom;
      if (phase == 0 && mem_req_valid === 1'b1) begin
        phase = 1;
        cnt = 0;
      end
      if (phase == 1) begin
        if (cnt == ready_lat) begin
          mem_req_ready = 1'b1;
          if ($urandom_range(0, 1) == 1) mem_resp_valid = 1'b1;
          phase = 2;
          cnt = 0;
        end else cnt++;
      end else if (phase == 2) begin
        if (!never_resp && cnt == resp_lat) begin
          mem_resp_valid = 1'b1;
          mem_resp_data  = rd_word;
          phase = 0;
        end else if (never_resp && cnt == TMO + 1) begin
          mem_resp_valid = 1'b1;
          mem_resp_data  = 32'hFFFFFFFF;
          phase = 0;
        end else cnt++;
      end
    end
  end

  // monitor: request fields against the scoreboard head every valid cycle,
  // cpu_rdata against the expected result when stall falls
  initial begin
    bit   prev_stall = 1'b0;
    req_t e;
    forever begin
      @(negedge clk);
      #2;
      if (reset !== 1'b1) prev_stall = 1'b0;
      else begin
        if (mem_req_valid === 1'b1) begin
          if (req_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_req actual=valid required=idle at %0t", $time);
          end else begin
            e = req_q[0];
            check("req_rw", 32'(mem_req_rw), 32'(e.rw));
            check("req_addr", 32'(mem_req_addr), 32'(e.addr));
            check("req_mask", 32'(mem_req_mask), 32'(e.mask));
            if (e.rw) check("req_data", mem_req_data, e.data);
            if (mem_req_ready === 1'b1) void'(req_q.pop_front());
          end
        end
        if (prev_stall && stall === 1'b0) begin
          if (comp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_done actual=done required=none at %0t", $time);
          end else check("cpu_rdata", cpu_rdata, comp_q.pop_front());
        end
        prev_stall = (stall === 1'b1);
      end
    end
  end

  task automatic drive_idle();
    cpu_we = 1'b0; cpu_re = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
    st_size = 2'd0; ld_size = 3'd0;
  endtask

  task automatic do_access(input bit we, input bit re, input logic [31:0] a,
                           input logic [31:0] wd, input logic [1:0] sts, input logic [2:0] lds,
                           input int rlat, input int plat, input bit nresp, input logic [31:0] word);
    req_t e;
    int   nst, nerr, exp_st, exp_err;
    bit   done;
    ready_lat = rlat; resp_lat = plat; never_resp = nresp; rd_word = word;
    e.rw   = we;
    e.addr = 30'(a / 4);
    e.mask = we ? model_mask(sts, a) : 4'd0;
    e.data = we ? model_wdata(sts, wd) : 32'd0;
    req_q.push_back(e);
    if (!we) last_rdata = nresp ? 32'd0 : model_load(lds, a, word);
    comp_q.push_back(last_rdata);
    exp_st  = 1 + (rlat + 1) + (nresp ? TMO : plat + 1);
    exp_err = ((we && re) ? 1 : 0) + (nresp ? 1 : 0);
    @(negedge clk);
    cpu_we = we; cpu_re = re; cpu_addr = a; cpu_wdata = wd; st_size = sts; ld_size = lds;
    nst = 0; nerr = 0; done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (stall === 1'b1) nst++; else done = 1'b1;
      if (err === 1'b1) nerr++;
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      drive_idle();
      #1;
      if (err === 1'b1) nerr++;
    end
    check("stall_cycles", 32'(nst), 32'(exp_st));
    check("err_pulses", 32'(nerr), 32'(exp_err));
  endtask

  task automatic do_invalid(input bit we, input logic [1:0] sts, input logic [2:0] lds);
    @(negedge clk);
    cpu_we = we; cpu_re = ~we; cpu_addr = $urandom; cpu_wdata = $urandom;
    st_size = sts; ld_size = lds;
    #1;
    check("inv_stall", 32'(stall), 32'd0);
    check("inv_err_early", 32'(err), 32'd0);
    @(negedge clk);
    drive_idle();
    #1;
    check("inv_err", 32'(err), 32'd1);
    check("inv_valid", 32'(mem_req_valid), 32'd0);
    @(negedge clk);
    #1;
    check("inv_err_clear", 32'(err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] lds_tab[5];
    logic [2:0] lds;
    logic [1:0] sts;
    bit         we, re;
    lds_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    drive_idle();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_rdata", cpu_rdata, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_valid", 32'(mem_req_valid), 32'd0);
    reset = 1'b1;

    do_access(1, 0, 32'h100, 32'hDEADBEEF, 2'd2, 3'd0, 0, 0, 0, 32'd0);
    do_access(1, 0, 32'h103, 32'h000000A5, 2'd0, 3'd0, 0, 0, 0, 32'd0);
    do_access(1, 0, 32'h102, 32'h00001234, 2'd1, 3'd0, 0, 1, 0, 32'd0);
    do_access(0, 1, 32'h3, 32'd0, 2'd0, 3'd0, 0, 0, 0, 32'h80FF7F01);
    do_access(0, 1, 32'h3, 32'd0, 2'd0, 3'd4, 1, 0, 0, 32'h80FF7F01);
    do_access(0, 1, 32'h2, 32'd0, 2'd0, 3'd1, 0, 2, 0, 32'h80FF7F01);
    do_access(0, 1, 32'h0, 32'd0, 2'd0, 3'd5, 0, 0, 0, 32'h80FF7F01);
    do_access(0, 1, 32'h8, 32'd0, 2'd0, 3'd2, 0, 0, 0, 32'h80FF7F01);
    do_access(1, 0, 32'h204, 32'hCAFEF00D, 2'd2, 3'd0, 4, 0, 0, 32'd0);
    do_access(0, 1, 32'h44, 32'd0, 2'd0, 3'd2, 0, TMO - 1, 0, 32'h13579BDF);
    do_access(0, 1, 32'h48, 32'd0, 2'd0, 3'd2, 1, 0, 1, 32'h2468ACE0);
    do_access(1, 0, 32'h50, 32'h11111111, 2'd2, 3'd0, 0, 0, 0, 32'd0);
    do_access(1, 1, 32'h60, 32'h55AA55AA, 2'd2, 3'd2, 0, 0, 0, 32'd0);
    do_invalid(1, 2'd3, 3'd0);
    do_invalid(0, 2'd0, 3'd3);

    for (int i = 0; i < 40; i++) begin
      we  = ($urandom_range(0, 1) == 1);
      re  = we ? ($urandom_range(0, 7) == 0) : 1'b1;
      sts = 2'($urandom_range(0, 2));
      lds = lds_tab[$urandom_range(0, 4)];
      do_access(we, re, $urandom, $urandom, sts, lds, $urandom_range(0, 5),
                $urandom_range(0, TMO - 1), 0, $urandom);
    end

    // reset during WAIT: stall and request drop at once, late response discarded
    ready_lat = 0; resp_lat = 1; never_resp = 1'b0; rd_word = 32'h89ABCDEF;
    begin
      req_t e;
      e.rw = 1'b0; e.addr = 30'h10; e.mask = 4'd0; e.data = 32'd0;
      req_q.push_back(e);
    end
    @(negedge clk);
    cpu_we = 1'b0; cpu_re = 1'b1; cpu_addr = 32'h40; ld_size = 3'd2;
    repeat (2) @(negedge clk);
    #1;
    check("wait_stall", 32'(stall), 32'd1);
    reset = 1'b0;
    #1;
    check("rstw_stall", 32'(stall), 32'd0);
    check("rstw_valid", 32'(mem_req_valid), 32'd0);
    repeat (3) @(negedge clk);
    drive_idle();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rstw_rdata", cpu_rdata, 32'd0);
    check("rstw_idle_stall", 32'(stall), 32'd0);
    check("rstw_idle_valid", 32'(mem_req_valid), 32'd0);
    last_rdata = 32'd0;
    do_access(1, 0, 32'h70, 32'h0BADF00D, 2'd2, 3'd0, 0, 0, 0, 32'd0);
    repeat (2) @(negedge clk);
    check("queues_drained", 32'(req_q.size() + comp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
